// File: rtl/tl_a_arbiter_pkg.sv
// TileLink A-channel payload, opcode constants and beat-count helpers.
// No timing or backpressure of its own.
package tl_a_arbiter_pkg;

    localparam int DATA_BITS     = 64;
    localparam int LG_BEAT_BYTES = $clog2(DATA_BITS / 8);

    localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
    localparam logic [2:0] ARITHMETIC_DATA  = 3'd2;
    localparam logic [2:0] LOGICAL_DATA     = 3'd3;
    localparam logic [2:0] GET              = 3'd4;
    localparam logic [2:0] INTENT           = 3'd5;
    localparam logic [2:0] ACQUIRE_BLOCK    = 3'd6;
    localparam logic [2:0] ACQUIRE_PERM     = 3'd7;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [3:0]  size;
        logic [7:0]  source;
        logic [31:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        corrupt;
    } tl_a_bundle_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    function automatic logic tl_has_data(input logic [2:0] opcode);
        return opcode <= LOGICAL_DATA;
    endfunction

    // size is log2(bytes); anything up to one beat's width is a single beat
    function automatic logic [15:0] tl_num_beats(input logic [2:0] opcode, input logic [3:0] size);
        logic [15:0] beats;
        beats = 16'd1;
        if (tl_has_data(opcode) && (size > 4'(LG_BEAT_BYTES))) begin
            beats = 16'd1 << (size - 4'(LG_BEAT_BYTES));
        end
        return beats;
    endfunction

endpackage

// File: rtl/tl_a_arbiter_picker.sv
// Round-robin priority picker: first request strictly after rr_ptr, wrapping.
// Purely combinational; no backpressure handling.
module tl_rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic [IW-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(rr_ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_a_arbiter.sv
// Round-robin merge of NUM_CLIENTS TileLink A streams; multi-beat bursts hold the grant.
// Zero latency; in_ready is out_ready steered to the granted client only.
module tl_a_arbiter
    import tl_a_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int BEAT_CNT_W  = 8,
    localparam int IW = $clog2(NUM_CLIENTS)
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            in_valid,
    output logic [NUM_CLIENTS-1:0]            in_ready,
    input  tl_a_bundle_t [NUM_CLIENTS-1:0]    in_bits,
    output logic                              out_valid,
    input  logic                              out_ready,
    output tl_a_bundle_t                      out_bits,
    output logic [NUM_CLIENTS-1:0]            out_grant,
    output logic                              out_last
);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         lock_q, lock_d;
    logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;

    logic [NUM_CLIENTS-1:0] pick_grant;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic [15:0]            pick_beats;
    logic [IW-1:0]          sel_idx;
    logic                   fire;

    tl_rr_picker #(.N(NUM_CLIENTS)) u_picker (
        .req    (in_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign pick_beats = tl_num_beats(in_bits[pick_idx].opcode, in_bits[pick_idx].size);
    assign fire       = out_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= IW'(NUM_CLIENTS - 1);
            lock_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        cnt_d    = cnt_q;
        if (fire) begin
            if (state_q == ST_IDLE) begin
                rr_ptr_d = pick_idx;
                if (pick_beats != 16'd1) begin
                    state_d = ST_BURST;
                    lock_d  = pick_idx;
                    cnt_d   = BEAT_CNT_W'(pick_beats - 16'd1);
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == BEAT_CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // Reset gates the handshake outputs combinationally so nothing fires while held.
    always_comb begin
        sel_idx   = pick_idx;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_grant = '0;
        if (state_q == ST_BURST) begin
            sel_idx   = lock_q;
            out_valid = in_valid[lock_q];
            out_last  = in_valid[lock_q] && (cnt_q == BEAT_CNT_W'(1));
        end else begin
            out_valid = pick_any;
            out_last  = pick_any && (pick_beats == 16'd1);
        end
        if (out_valid) begin
            out_grant[sel_idx] = 1'b1;
        end
        if (reset) begin
            out_valid = 1'b0;
            out_last  = 1'b0;
            out_grant = '0;
        end
        out_bits = in_bits[sel_idx];
        in_ready = out_ready ? out_grant : '0;
    end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Directed bench for tl_a_arbiter: reset, rotation, burst locking, stalls, mid-burst reset.
module tb_tl_a_arbiter;
    import tl_a_arbiter_pkg::*;

    localparam int N = 4;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [N-1:0]             in_valid;
    logic [N-1:0]             in_ready;
    tl_a_bundle_t [N-1:0]     in_bits;
    logic                     out_valid;
    logic                     out_ready;
    tl_a_bundle_t             out_bits;
    logic [N-1:0]             out_grant;
    logic                     out_last;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    tl_a_arbiter #(.NUM_CLIENTS(N), .BEAT_CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_grant (out_grant),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic tl_a_bundle_t mk(input logic [2:0] op, input logic [3:0] size,
                                        input logic [7:0] src, input logic [7:0] tag);
        tl_a_bundle_t b;
        b         = '0;
        b.opcode  = op;
        b.size    = size;
        b.source  = src;
        b.address = {src, 16'h0, tag};
        b.mask    = 8'hFF;
        b.data    = {8{tag}};
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int fires;
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '1;
        for (int i = 0; i < N; i++) in_bits[i] = mk(GET, 4'd3, 8'(i), 8'h10);

        // Outputs held low while reset is asserted, even with requests present
        #2;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_in_ready",  128'(in_ready),  128'(4'b0000));
        check("rst_out_grant", 128'(out_grant), 128'(4'b0000));
        check("rst_out_last",  128'(out_last),  128'(1'b0));
        @(negedge clock);
        reset = 1'b0;

        // Single Get from client 0
        in_valid    = 4'b0001;
        in_bits[0]  = mk(GET, 4'd3, 8'd0, 8'h21);
        out_ready   = 1'b1;
        #1;
        check("single_valid", 128'(out_valid), 128'(1'b1));
        check("single_grant", 128'(out_grant), 128'(4'b0001));
        check("single_ready", 128'(in_ready),  128'(4'b0001));
        check("single_last",  128'(out_last),  128'(1'b1));
        check("single_bits",  128'(out_bits),  128'(mk(GET, 4'd3, 8'd0, 8'h21)));
        @(negedge clock);
        in_valid   = 4'b0011;
        in_bits[1] = mk(GET, 4'd3, 8'd1, 8'h22);
        #1;
        check("single_then_c1", 128'(out_grant), 128'(4'b0010));

        // Rotation with all clients requesting Gets
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_bits[i] = mk(GET, 4'd3, 8'(i), 8'h30);
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("rr_grant%0d", c), 128'(out_grant), 128'(4'b0001 << (c % 4)));
            check($sformatf("rr_src%0d", c),   128'(out_bits.source), 128'(c % 4));
            @(negedge clock);
        end

        // 8-beat PutFullData from client 1 while client 2 waits with a Get
        do_reset();
        in_valid   = 4'b0110;
        out_ready  = 1'b1;
        in_bits[2] = mk(GET, 4'd3, 8'd2, 8'h40);
        for (int b = 0; b < 8; b++) begin
            in_bits[1] = mk(PUT_FULL_DATA, 4'd6, 8'd1, 8'(b));
            #1;
            check($sformatf("burst_grant%0d", b), 128'(out_grant), 128'(4'b0010));
            check($sformatf("burst_ready%0d", b), 128'(in_ready),  128'(4'b0010));
            check($sformatf("burst_last%0d", b),  128'(out_last),  128'(b == 7));
            check($sformatf("burst_bits%0d", b),  128'(out_bits),
                  128'(mk(PUT_FULL_DATA, 4'd6, 8'd1, 8'(b))));
            @(negedge clock);
        end
        #1;
        check("burst_after_grant", 128'(out_grant), 128'(4'b0100));
        check("burst_after_last",  128'(out_last),  128'(1'b1));

        // Burst with out_ready toggling; clients 2 and 3 must wait
        do_reset();
        in_valid   = 4'b1110;
        in_bits[1] = mk(PUT_FULL_DATA, 4'd6, 8'd1, 8'h50);
        in_bits[2] = mk(GET, 4'd3, 8'd2, 8'h51);
        in_bits[3] = mk(GET, 4'd3, 8'd3, 8'h52);
        fires = 0;
        for (int c = 0; c < 20 && fires < 8; c++) begin
            out_ready = (c % 2 == 0);
            #1;
            check($sformatf("stall_grant%0d", c), 128'(out_grant), 128'(4'b0010));
            check($sformatf("stall_ready%0d", c), 128'(in_ready),
                  128'(out_ready ? 4'b0010 : 4'b0000));
            check($sformatf("stall_last%0d", c),  128'(out_last),  128'(fires == 7));
            if (out_ready) fires++;
            @(negedge clock);
        end
        check("stall_fires", 128'(fires), 128'(8));
        out_ready = 1'b1;
        #1;
        check("stall_after_grant", 128'(out_grant), 128'(4'b0100));

        // Reset after 3 of 8 beats abandons the burst
        do_reset();
        in_valid   = 4'b0010;
        out_ready  = 1'b1;
        in_bits[1] = mk(PUT_FULL_DATA, 4'd6, 8'd1, 8'h60);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_valid", 128'(out_valid), 128'(1'b0));
        check("midrst_grant", 128'(out_grant), 128'(4'b0000));
        check("midrst_ready", 128'(in_ready),  128'(4'b0000));
        check("midrst_last",  128'(out_last),  128'(1'b0));
        @(negedge clock);
        reset      = 1'b0;
        in_valid   = 4'b0011;
        in_bits[0] = mk(GET, 4'd3, 8'd0, 8'h61);
        in_bits[1] = mk(GET, 4'd3, 8'd1, 8'h62);
        #1;
        check("midrst_after_grant", 128'(out_grant), 128'(4'b0001));
        check("midrst_after_last",  128'(out_last),  128'(1'b1));

        // Small PutPartialData is a single beat and takes no lock
        do_reset();
        in_valid   = 4'b0001;
        out_ready  = 1'b1;
        in_bits[0] = mk(PUT_PARTIAL_DATA, 4'd2, 8'd0, 8'h70);
        #1;
        check("ppd_grant", 128'(out_grant), 128'(4'b0001));
        check("ppd_last",  128'(out_last),  128'(1'b1));
        @(negedge clock);
        in_valid   = 4'b0011;
        in_bits[0] = mk(GET, 4'd3, 8'd0, 8'h71);
        in_bits[1] = mk(GET, 4'd3, 8'd1, 8'h72);
        #1;
        check("ppd_no_lock", 128'(out_grant), 128'(4'b0010));
        check("ppd_no_lock_bits", 128'(out_bits), 128'(mk(GET, 4'd3, 8'd1, 8'h72)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
